// File: rtl/cr16_control_if.sv
// Bus between the CR16 multicycle controller, memory, register file and PSR.
// The controller takes the master side; the datapath/memory side is the slave.
interface cr16_control_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] instr;
  logic             memReady;
  logic [WIDTH-1:0] srcValue;
  logic [4:0]       flags;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] memAddr;
  logic             memRead;
  logic             memWrite;
  logic [3:0]       sourceAddr;
  logic [3:0]       destAddr;
  logic             regWrite;
  logic             wbSel;
  logic [3:0]       aluOp;
  logic             useImm;
  logic [WIDTH-1:0] imm;
  logic             flagWrite;
  logic [2:0]       state;

  modport master (
    input  instr, memReady, srcValue, flags,
    output pc, memAddr, memRead, memWrite, sourceAddr, destAddr,
           regWrite, wbSel, aluOp, useImm, imm, flagWrite, state
  );

  modport slave (
    output instr, memReady, srcValue, flags,
    input  pc, memAddr, memRead, memWrite, sourceAddr, destAddr,
           regWrite, wbSel, aluOp, useImm, imm, flagWrite, state
  );
endinterface

// File: rtl/cr16_control.sv
// Multicycle fetch/decode/execute controller for the CR16-style datapath.
// Sole source of register file and PSR write enables; outputs are Moore-decoded from state and IR.
//
// state  | meaning
// FETCH  | read instr at pc; on memReady latch IR, pc+1
// DECODE | register addresses settle, no enables
// EXEC   | ALU writeback / flag update, branch or jump resolve
// MEM    | LOAD read or STOR write at srcValue, waits on memReady
// WB     | write loaded data into Rdest
module cr16_control #(parameter int WIDTH = 16) (
  input logic clk,
  input logic reset,
  cr16_control_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } stateT;

  stateT            stateQ, stateNext;
  logic [WIDTH-1:0] pcQ, pcNext, irQ, irNext;
  logic [3:0]       opcode, opExt, cond, aluCode;
  logic             isRType, isAlu, isCmp, flagOp, isLoad, isStor, isJcond, isBcond;
  logic             condTrue, zFlag, nFlag;
  logic [WIDTH-1:0] immSext, immZext, immLui, immSel;
  logic             memRead, memWrite, regWrite, wbSel, flagWrite;

  function automatic logic isAluCode(input logic [3:0] c);
    case (c)
      4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= FETCH;
      pcQ    <= '0;
      irQ    <= '0;
    end else begin
      stateQ <= stateNext;
      pcQ    <= pcNext;
      irQ    <= irNext;
    end
  end

  assign opcode  = irQ[15:12];
  assign cond    = irQ[11:8];
  assign opExt   = irQ[7:4];
  assign isRType = (opcode == 4'b0000);
  assign aluCode = isRType ? opExt : opcode;
  assign isAlu   = isAluCode(aluCode) || (!isRType && opcode == 4'b1111);
  assign isCmp   = (aluCode == 4'b1011);
  assign flagOp  = isAlu && (aluCode == 4'b0101 || aluCode == 4'b1001 || aluCode == 4'b1011);
  assign isLoad  = (opcode == 4'b0100) && (opExt == 4'b0000);
  assign isStor  = (opcode == 4'b0100) && (opExt == 4'b0100);
  assign isJcond = (opcode == 4'b0100) && (opExt == 4'b1100);
  assign isBcond = (opcode == 4'b1100);

  // Only Z and N steer conditions; masking keeps the whole flag bus referenced.
  assign zFlag = |(bus.flags & 5'b00010);
  assign nFlag = |(bus.flags & 5'b00001);

  always_comb begin
    condTrue = 1'b0;
    case (cond)
      4'b0000: condTrue = zFlag;
      4'b0001: condTrue = !zFlag;
      4'b1100: condTrue = nFlag;
      4'b1110: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  end

  assign immSext = {{(WIDTH-8){irQ[7]}}, irQ[7:0]};
  assign immZext = {{(WIDTH-8){1'b0}}, irQ[7:0]};
  assign immLui  = immZext << 8;

  always_comb begin
    immSel = '0;
    case (opcode)
      4'b0101, 4'b1001, 4'b1011, 4'b1100: immSel = immSext;
      4'b0001, 4'b0010, 4'b0011, 4'b1101: immSel = immZext;
      4'b1111:                            immSel = immLui;
      default:                            immSel = '0;
    endcase
  end

  always_comb begin
    stateNext = FETCH;
    pcNext    = pcQ;
    irNext    = irQ;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    wbSel     = 1'b0;
    flagWrite = 1'b0;
    case (stateQ)
      FETCH: begin
        memRead = 1'b1;
        if (bus.memReady) begin
          irNext    = bus.instr;
          pcNext    = pcQ + WIDTH'(1);
          stateNext = DECODE;
        end else begin
          stateNext = FETCH;
        end
      end
      DECODE: stateNext = EXEC;
      EXEC: begin
        regWrite  = isAlu && !isCmp;
        flagWrite = flagOp;
        // pc already points past this instruction, so the displacement is relative to pc+1
        if (isBcond && condTrue) pcNext = pcQ + immSext;
        if (isJcond && condTrue) pcNext = bus.srcValue;
        stateNext = (isLoad || isStor) ? MEM : FETCH;
      end
      MEM: begin
        memRead   = isLoad;
        memWrite  = isStor;
        stateNext = MEM;
        if (bus.memReady) stateNext = isLoad ? WB : FETCH;
      end
      WB: begin
        regWrite = 1'b1;
        wbSel    = 1'b1;
      end
      default: stateNext = FETCH;
    endcase
  end

  assign bus.pc         = pcQ;
  assign bus.memAddr    = (stateQ == FETCH) ? pcQ : bus.srcValue;
  assign bus.memRead    = memRead;
  assign bus.memWrite   = memWrite;
  assign bus.sourceAddr = irQ[3:0];
  assign bus.destAddr   = irQ[11:8];
  assign bus.regWrite   = regWrite;
  assign bus.wbSel      = wbSel;
  assign bus.aluOp      = aluCode;
  assign bus.useImm     = isAlu && !isRType;
  assign bus.imm        = immSel;
  assign bus.flagWrite  = flagWrite;
  assign bus.state      = stateQ;
endmodule
